// File: rtl/tmds_pkg.sv
// Shared TMDS constants: mode encodings, control symbols, TERC4 table and small helpers.
// The TERC4 table is only referenced when TMDS_TERC4_EN is defined.
package tmds_pkg;

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'd0,
    MODE_VIDEO = 2'd1,
    MODE_TERC4 = 2'd2,
    MODE_RSVD  = 2'd3
  } tmds_mode_e;

  localparam logic [9:0] CTRL_SYM_00 = 10'h354;
  localparam logic [9:0] CTRL_SYM_01 = 10'h0AB;
  localparam logic [9:0] CTRL_SYM_10 = 10'h154;
  localparam logic [9:0] CTRL_SYM_11 = 10'h2AB;

  // Entry n sits at slice [n]; listed from nibble F down to nibble 0.
  localparam logic [15:0][9:0] TERC4_TAB = {
    10'h2C3, 10'h163, 10'h271, 10'h28E,
    10'h2C6, 10'h19C, 10'h139, 10'h2CC,
    10'h13C, 10'h18E, 10'h11E, 10'h171,
    10'h2E2, 10'h2E4, 10'h263, 10'h29C
  };

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_SYM_00;
      2'b01:   s = CTRL_SYM_01;
      2'b10:   s = CTRL_SYM_10;
      2'b11:   s = CTRL_SYM_11;
      default: s = CTRL_SYM_00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage 1 builds q_m, stage 2 applies DC balancing and owns the
// running disparity. TERC4 symbols are produced only when TMDS_TERC4_EN is defined.
module tmds_channel_enc
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] mode,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
`ifdef TMDS_TERC4_EN
  input  logic [3:0] aux,
`endif
  output logic       out_valid,
  output logic [9:0] q_out
);

  logic [3:0]        n1_d_s;
  logic              use_xnor_s;
  logic [8:0]        qm_s;

  logic              v1_r;
  tmds_mode_e        mode_r;
  logic [1:0]        ctrl_r;
  logic [8:0]        qm_r;
`ifdef TMDS_TERC4_EN
  logic [3:0]        aux_r;
`endif

  logic [3:0]        n1_q_s;
  logic signed [4:0] diff_s;
  logic [9:0]        q_s;
  logic signed [4:0] cnt_nx_s;

  logic              ov_r;
  logic [9:0]        q_r;
  logic signed [4:0] cnt_r;

  // Stage 1 combinational: transition-minimising XOR/XNOR chain.
  always_comb begin
    n1_d_s     = popcount8(data);
    use_xnor_s = (n1_d_s > 4'd4) || ((n1_d_s == 4'd4) && (data[0] == 1'b0));
    qm_s       = 9'd0;
    qm_s[0]    = data[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor_s) begin
        qm_s[i] = ~(qm_s[i-1] ^ data[i]);
      end else begin
        qm_s[i] = qm_s[i-1] ^ data[i];
      end
    end
    qm_s[8] = ~use_xnor_s;
  end

  // Stage 1 register: q_m plus the side-band fields it travels with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      mode_r <= MODE_CTRL;
      ctrl_r <= 2'b00;
      qm_r   <= 9'd0;
`ifdef TMDS_TERC4_EN
      aux_r  <= 4'd0;
`endif
    end else begin
      v1_r   <= in_valid;
      mode_r <= tmds_mode_e'(mode);
      ctrl_r <= ctrl;
      qm_r   <= qm_s;
`ifdef TMDS_TERC4_EN
      aux_r  <= aux;
`endif
    end
  end

  // Stage 2 combinational: symbol selection and next disparity.
  always_comb begin
    n1_q_s   = popcount8(qm_r[7:0]);
    // ones minus zeros of q_m[7:0]; modular 5-bit math is exact in the -8..+8 range
    diff_s   = signed'({n1_q_s, 1'b0}) - 5'sd8;
    q_s      = q_r;
    cnt_nx_s = cnt_r;
    case (mode_r)
      MODE_VIDEO: begin
        if ((cnt_r == 5'sd0) || (n1_q_s == 4'd4)) begin
          q_s = {~qm_r[8], qm_r[8], (qm_r[8] ? qm_r[7:0] : ~qm_r[7:0])};
          if (qm_r[8]) begin
            cnt_nx_s = cnt_r + diff_s;
          end else begin
            cnt_nx_s = cnt_r - diff_s;
          end
        end else if ((!cnt_r[4] && (n1_q_s > 4'd4)) || (cnt_r[4] && (n1_q_s < 4'd4))) begin
          q_s      = {1'b1, qm_r[8], ~qm_r[7:0]};
          cnt_nx_s = cnt_r + signed'({3'b000, qm_r[8], 1'b0}) - diff_s;
        end else begin
          q_s      = {1'b0, qm_r[8], qm_r[7:0]};
          cnt_nx_s = cnt_r - signed'({3'b000, ~qm_r[8], 1'b0}) + diff_s;
        end
      end
`ifdef TMDS_TERC4_EN
      MODE_TERC4: begin
        q_s      = TERC4_TAB[aux_r];
        cnt_nx_s = 5'sd0;
      end
`endif
      default: begin
        q_s      = ctrl_sym(ctrl_r);
        cnt_nx_s = 5'sd0;
      end
    endcase
  end

  // Stage 2 register: output symbol and running disparity, held across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_r  <= 1'b0;
      q_r   <= 10'd0;
      cnt_r <= 5'sd0;
    end else if (v1_r) begin
      ov_r  <= 1'b1;
      q_r   <= q_s;
      cnt_r <= cnt_nx_s;
    end else begin
      ov_r  <= 1'b0;
    end
  end

  assign out_valid = ov_r;
  assign q_out     = q_r;

endmodule

// File: rtl/tmds_encoder_pipe.sv
// NUM_CH-wide TMDS encoder with two-register latency. Define TMDS_TERC4_EN to
// enable TERC4 data-island symbols in mode 2; otherwise mode 2 acts as control.
module tmds_encoder_pipe
  import tmds_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [1:0]            mode,
  input  logic [8*NUM_CH-1:0]   data,
  input  logic [2*NUM_CH-1:0]   ctrl,
  input  logic [4*NUM_CH-1:0]   aux,
  output logic                  out_valid,
  output logic [10*NUM_CH-1:0]  q_out
);

  logic [NUM_CH-1:0] ch_valid_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tmds_channel_enc u_enc (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .mode      (mode),
      .data      (data[8*c +: 8]),
      .ctrl      (ctrl[2*c +: 2]),
`ifdef TMDS_TERC4_EN
      .aux       (aux[4*c +: 4]),
`endif
      .out_valid (ch_valid_s[c]),
      .q_out     (q_out[10*c +: 10])
    );
  end

  // All channels share one valid pipeline, so the per-channel flags are identical.
  assign out_valid = &ch_valid_s;

`ifndef TMDS_TERC4_EN
  logic unused_aux_s;
  assign unused_aux_s = ^aux;
`endif

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Self-checking bench for tmds_encoder_pipe: directed steps plus random video
// against a reference model; TERC4 expectations follow TMDS_TERC4_EN.
module tb_tmds_encoder_pipe;

  localparam int NCH = 3;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [1:0]      mode;
  logic [8*NCH-1:0]  data;
  logic [2*NCH-1:0]  ctrl;
  logic [4*NCH-1:0]  aux;
  logic            out_valid;
  logic [10*NCH-1:0] q_out;

  tmds_encoder_pipe #(.NUM_CH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .data      (data),
    .ctrl      (ctrl),
    .aux       (aux),
    .out_valid (out_valid),
    .q_out     (q_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              v;
    logic [10*NCH-1:0] q;
    logic [NCH-1:0][7:0] c;
  } exp_t;

  exp_t        expq[$];
  int          vectors;
  int          misc;
  int          m_cnt [NCH];
  logic [10*NCH-1:0] m_q;
  logic [9:0]  ctrl_tab [4];
  logic [9:0]  terc_tab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dut_cnt(input int ch);
    case (ch)
      0:       return int'(dut.g_ch[0].u_enc.cnt_r);
      1:       return int'(dut.g_ch[1].u_enc.cnt_r);
      2:       return int'(dut.g_ch[2].u_enc.cnt_r);
      default: return 999;
    endcase
  endfunction

  // Reference video encoder: pick q_m, then choose the word that pulls the
  // running disparity back toward zero.
  function automatic logic [9:0] ref_video(input logic [7:0] d, input int rd);
    int         ones;
    int         bal;
    bit         use_xnor;
    logic [8:0] qm;
    ones     = $countones(d);
    use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    bal   = 2 * $countones(qm[7:0]) - 8;
    if (rd == 0 || bal == 0) return qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
    if ((rd > 0 && bal > 0) || (rd < 0 && bal < 0)) return {1'b1, qm[8], ~qm[7:0]};
    return {1'b0, qm[8], qm[7:0]};
  endfunction

  // Running disparity moves by the ones-minus-zeros of each emitted video word.
  function automatic int disp10(input logic [9:0] s);
    return 2 * $countones(s) - 10;
  endfunction

  task automatic cycle(input logic v, input logic [1:0] md, input logic [8*NCH-1:0] d,
                       input logic [2*NCH-1:0] c, input logic [4*NCH-1:0] a);
    exp_t e;
    logic [9:0] sym;
    @(negedge clk);
    if (expq.size() >= 2) begin
      e = expq.pop_front();
      chk("out_valid", out_valid, e.v);
      chk("q_out", q_out, e.q);
      for (int ch = 0; ch < NCH; ch++) chk("cnt", dut_cnt(ch), int'(signed'(e.c[ch])));
    end
    if (v) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (md == 2'd1) begin
          sym = ref_video(d[8*ch +: 8], m_cnt[ch]);
          m_cnt[ch] = m_cnt[ch] + disp10(sym);
`ifdef TMDS_TERC4_EN
        end else if (md == 2'd2) begin
          sym = terc_tab[a[4*ch +: 4]];
          m_cnt[ch] = 0;
`endif
        end else begin
          sym = ctrl_tab[c[2*ch +: 2]];
          m_cnt[ch] = 0;
        end
        m_q[10*ch +: 10] = sym;
      end
    end
    e.v = v;
    e.q = m_q;
    for (int ch = 0; ch < NCH; ch++) e.c[ch] = m_cnt[ch][7:0];
    expq.push_back(e);
    in_valid = v;
    mode     = md;
    data     = d;
    ctrl     = c;
    aux      = a;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_q_out"}, q_out, '0);
    for (int ch = 0; ch < NCH; ch++) chk({tag, "_cnt"}, dut_cnt(ch), 0);
  endtask

  task automatic model_clear();
    expq.delete();
    m_q = '0;
    for (int ch = 0; ch < NCH; ch++) m_cnt[ch] = 0;
  endtask

  // Reset pulse placed between clock edges, checked before any edge arrives.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    reset_check("midrst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] r1;
  logic [31:0] r2;

  initial begin
    vectors  = 0;
    misc     = 0;
    ctrl_tab = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    terc_tab = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                 10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
    rst_n    = 1'b1;
    in_valid = 1'b0;
    mode     = 2'd0;
    data     = '0;
    ctrl     = '0;
    aux      = '0;
    model_clear();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_check("reset");
    rst_n = 1'b1;

    // Two zero bytes: first DC-balanced from cnt=0, second inverted to pull back.
    cycle(1'b1, 2'd1, 24'h000000, 6'h00, 12'h000);
    cycle(1'b1, 2'd1, 24'h000000, 6'h00, 12'h000);
    cycle(1'b0, 2'd1, 24'h000000, 6'h00, 12'h000);
    chk("zero0_sym", q_out[9:0], 10'h100);
    chk("zero0_cnt", dut_cnt(0), -8);
    cycle(1'b0, 2'd1, 24'h000000, 6'h00, 12'h000);
    chk("zero1_sym", q_out[9:0], 10'h3FF);
    chk("zero1_cnt", dut_cnt(0), 2);

    // Video, then control clears disparity, then video restarts from zero.
    cycle(1'b1, 2'd1, 24'hFF55A3, 6'h00, 12'h000);
    cycle(1'b1, 2'd1, 24'h10FE7C, 6'h00, 12'h000);
    cycle(1'b1, 2'd0, 24'h000000, 6'b11_01_00, 12'h000);
    cycle(1'b1, 2'd1, 24'h000000, 6'h00, 12'h000);
    cycle(1'b0, 2'd1, 24'h000000, 6'h00, 12'h000);
    chk("ctrl_sym", q_out[9:0], 10'h354);
    chk("ctrl_cnt", dut_cnt(0), 0);
    cycle(1'b0, 2'd1, 24'h000000, 6'h00, 12'h000);
    chk("after_ctrl_sym", q_out[9:0], 10'h100);

    // Reserved mode behaves as control.
    cycle(1'b1, 2'd3, 24'h123456, 6'b10_01_11, 12'h000);
    // Mode 2 with aux nibbles 0,5,F.
    cycle(1'b1, 2'd2, 24'h000000, 6'b01_01_01, 12'hF50);
    cycle(1'b0, 2'd1, 24'h000000, 6'h00, 12'h000);
    chk("rsvd_sym", q_out[9:0], 10'h2AB);
    cycle(1'b0, 2'd1, 24'h000000, 6'h00, 12'h000);
`ifdef TMDS_TERC4_EN
    chk("mode2_sym", q_out[9:0], 10'h29C);
`else
    chk("mode2_sym", q_out[9:0], 10'h0AB);
`endif
    chk("mode2_cnt", dut_cnt(0), 0);

    // Bubble: valid 1,0,1 with disparity held across the gap.
    cycle(1'b1, 2'd1, 24'h00FF00, 6'h00, 12'h000);
    cycle(1'b0, 2'd1, 24'hAAAAAA, 6'h00, 12'h000);
    cycle(1'b1, 2'd1, 24'h0F0F0F, 6'h00, 12'h000);
    cycle(1'b1, 2'd1, 24'h818181, 6'h00, 12'h000);

    // Reset mid-stream, then the first symbol must again be the cnt=0 encoding.
    mid_reset();
    cycle(1'b1, 2'd1, 24'h000000, 6'h00, 12'h000);
    cycle(1'b0, 2'd1, 24'h000000, 6'h00, 12'h000);
    cycle(1'b0, 2'd1, 24'h000000, 6'h00, 12'h000);
    chk("postrst_sym", q_out[9:0], 10'h100);
    chk("postrst_valid", out_valid, 1'b1);
    chk("postrst_cnt", dut_cnt(0), -8);

    // Random video on all channels with occasional bubbles.
    for (int n = 0; n < 10000; n++) begin
      r1 = $urandom();
      r2 = $urandom();
      cycle((r2[2:0] != 3'd0), 2'd1, r1[23:0], r2[13:8], r2[27:16]);
      for (int ch = 0; ch < NCH; ch++)
        chk("cnt_range", ((dut_cnt(ch) >= -8) && (dut_cnt(ch) <= 8)), 1'b1);
    end
    cycle(1'b0, 2'd1, 24'h000000, 6'h00, 12'h000);
    cycle(1'b0, 2'd1, 24'h000000, 6'h00, 12'h000);
    cycle(1'b0, 2'd1, 24'h000000, 6'h00, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
